// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Ports: clk, rst (async, active-low), start/flush/md_op (active-low), opr_1/opr_2 in; busy/done (active-low), result out.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes as soon as the multiplier runs out of set bits.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [7:0]      md_op,
    input  logic [XLEN-1:0] opr_1,
    input  logic [XLEN-1:0] opr_2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_mul_q, is_mul_d;
    logic             is_hi_q, is_hi_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_q, neg_d;

    // op decode
    logic [7:0]      oh;
    logic            one_hot;
    logic            dec_mul, dec_hi, dec_rem;
    logic            sgn_a, sgn_b;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        oh      = ~md_op;
        one_hot = (oh != 8'd0) && ((oh & (oh - 8'd1)) == 8'd0);
        dec_mul = 1'b0;
        dec_hi  = 1'b0;
        dec_rem = 1'b0;
        sgn_a   = 1'b0;
        sgn_b   = 1'b0;
        if (one_hot) begin
            unique case (1'b1)
                oh[7]: begin dec_mul = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
                oh[6]: begin dec_mul = 1'b1; dec_hi = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
                oh[5]: begin dec_mul = 1'b1; dec_hi = 1'b1; sgn_a = 1'b1; end
                oh[4]: begin dec_mul = 1'b1; dec_hi = 1'b1; end
                oh[3]: begin sgn_a = 1'b1; sgn_b = 1'b1; end
                oh[2]: ;
                oh[1]: begin dec_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
                oh[0]: dec_rem = 1'b1;
                default: ;
            endcase
        end
        neg_a = sgn_a & opr_1[XLEN-1];
        neg_b = sgn_b & opr_2[XLEN-1];
        mag_a = neg_a ? -opr_1 : opr_1;
        mag_b = neg_b ? -opr_2 : opr_2;
    end

    // one iteration of each algorithm
    logic [W2-1:0]   acc_n, prod;
    logic [XLEN:0]   rem_sh, sub;
    logic            ge;
    logic [XLEN-1:0] rem_n, quo_n, mplier_n, calc_res;
    logic            last;

    always_comb begin
        acc_n    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        // sign applied to the full product so the high half is correct
        prod     = neg_q ? -acc_n : acc_n;
        mplier_n = mplier_q >> 1;
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        sub      = rem_sh - {1'b0, dvsr_q};
        // partial remainder is always < divisor, so a borrow means rem_sh < divisor
        ge       = ~sub[XLEN];
        rem_n    = ge ? sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_n    = {quo_q[XLEN-2:0], ge};
        if (is_mul_q)
            calc_res = is_hi_q ? prod[W2-1:XLEN] : prod[XLEN-1:0];
        else if (is_rem_q)
            calc_res = neg_q ? -rem_n : rem_n;
        else
            calc_res = neg_q ? -quo_n : quo_n;
        last = (cnt_q == CNT_W'(1));
`ifdef MULDIV_EARLY_OUT_EN
        last = last | (is_mul_q && (mplier_n == '0));
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        is_hi_d  = is_hi_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush && !start && one_hot) begin
                    is_mul_d = dec_mul;
                    is_hi_d  = dec_hi;
                    is_rem_d = dec_rem;
                    neg_d    = dec_rem ? neg_a : (neg_a ^ neg_b);
                    cnt_d    = CNT_W'(XLEN);
                    acc_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    rem_d    = '0;
                    quo_d    = mag_a;
                    dvsr_d   = mag_b;
                    state_d  = S_CALC;
                    if (!dec_mul && (opr_2 == '0)) begin
                        result_d = dec_rem ? opr_1 : '1;
                        state_d  = S_DONE;
                    end else if (!dec_mul && sgn_a && (opr_1 == MIN_NEG)
                                 && (opr_2 == '1)) begin
                        result_d = dec_rem ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (dec_mul && (mag_b == '0)) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (!flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (is_mul_q) begin
                        acc_d    = acc_n;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_n;
                    end else begin
                        rem_d = rem_n;
                        quo_d = quo_n;
                    end
                    if (last) begin
                        result_d = calc_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            is_hi_q  <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            is_hi_q  <= is_hi_d;
            is_rem_q <= is_rem_d;
            neg_q    <= neg_d;
        end
    end

    assign busy   = (state_q == S_IDLE);
    assign done   = (state_q != S_DONE);
    assign result = result_q;

endmodule
